// File: rtl/qoa_lms_decoder_mc.sv
// Multi-channel QOA LMS sample decoder: byte-command front end, per-channel
// 4-tap history/weights, serial MAC and valid/ready PCM output.
//
//   state   | meaning
//   IDLE    | waiting for a header byte
//   LOAD_HI | next byte is target[15:8]
//   LOAD_LO | next byte is target[7:0]
//   MAC     | one tap per cycle; last tap fused with clamp into OUT
//   OUT     | sample held until out_ready, then LMS update
module qoa_lms_decoder_mc #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ACC_W  = 32
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            data_rdy,
  input  logic [7:0]      spi_in,
  input  logic [CH_W-1:0] in_ch,
  output logic            in_ready,
  output logic [15:0]     sample,
  output logic [CH_W-1:0] sample_ch,
  output logic            sample_valid,
  input  logic            out_ready
);

  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, MAC, OUT} state_t;
  state_t state, state_nxt;

  logic signed [15:0] hist [NUM_CH][4];
  logic signed [15:0] wgt  [NUM_CH][4];

  logic [CH_W-1:0]    ch;
  logic               clr_pend, ld_en, ld_sel;
  logic [1:0]         ld_idx, tap;
  logic [3:0]         sf;
  logic [2:0]         qr;
  logic signed [15:0] dq, delta, s_clamp;
  logic signed [31:0] prod;
  logic signed [ACC_W-1:0] acc, acc_nxt, pred;
  logic signed [ACC_W:0]   s_wide;
  logic accept, ch_ok, is_res, is_clr, is_load, handshake;

  function automatic logic signed [15:0] qoa_rom(input logic [3:0] f, input logic [2:0] q);
    logic [13:0] m [4];
    case (f)
      4'd0:    m = '{14'd1,    14'd3,    14'd5,    14'd7};
      4'd1:    m = '{14'd5,    14'd18,   14'd32,   14'd49};
      4'd2:    m = '{14'd16,   14'd53,   14'd95,   14'd147};
      4'd3:    m = '{14'd34,   14'd113,  14'd203,  14'd315};
      4'd4:    m = '{14'd63,   14'd210,  14'd378,  14'd588};
      4'd5:    m = '{14'd104,  14'd345,  14'd621,  14'd966};
      4'd6:    m = '{14'd158,  14'd528,  14'd950,  14'd1477};
      4'd7:    m = '{14'd228,  14'd760,  14'd1368, 14'd2128};
      4'd8:    m = '{14'd316,  14'd1053, 14'd1895, 14'd2947};
      4'd9:    m = '{14'd422,  14'd1405, 14'd2529, 14'd3934};
      4'd10:   m = '{14'd548,  14'd1828, 14'd3290, 14'd5117};
      4'd11:   m = '{14'd696,  14'd2320, 14'd4176, 14'd6496};
      4'd12:   m = '{14'd868,  14'd2893, 14'd5207, 14'd8099};
      4'd13:   m = '{14'd1064, 14'd3548, 14'd6386, 14'd9933};
      4'd14:   m = '{14'd1286, 14'd4288, 14'd7718, 14'd12005};
      default: m = '{14'd1536, 14'd5120, 14'd9216, 14'd14336};
    endcase
    return q[0] ? -$signed({2'b00, m[q[2:1]]}) : $signed({2'b00, m[q[2:1]]});
  endfunction

  assign accept    = data_rdy && in_ready;
  assign handshake = (state == OUT) && out_ready;
  assign ch_ok     = int'(in_ch) < NUM_CH;
  assign is_res    = spi_in[0];
  assign is_clr    = !spi_in[0] && (spi_in[7:4] == 4'hF);
  assign is_load   = !spi_in[0] && (spi_in[7:4] == 4'h0);

  assign prod    = hist[ch][tap] * wgt[ch][tap];
  assign acc_nxt = acc + ACC_W'(prod);
  assign pred    = acc_nxt >>> 13;
  assign s_wide  = (ACC_W+1)'(pred) + (ACC_W+1)'(dq);
  assign delta   = dq >>> 4;

  always_comb begin
    if (s_wide > (ACC_W+1)'(32767))       s_clamp = 16'sh7FFF;
    else if (s_wide < (ACC_W+1)'(-32768)) s_clamp = 16'sh8000;
    else                                  s_clamp = s_wide[15:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (is_res && ch_ok) state_nxt = MAC;
        else if (is_load)    state_nxt = LOAD_HI;
      end
      LOAD_HI: if (accept) state_nxt = LOAD_LO;
      LOAD_LO: if (accept) state_nxt = IDLE;
      MAC:     if (tap == 2'd3) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) || (state == LOAD_HI) || (state == LOAD_LO);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < 4; k++) begin
          hist[c][k] <= '0;
          wgt[c][k]  <= '0;
        end
      acc <= '0; tap <= '0; dq <= '0; ch <= '0; sf <= '0; qr <= '0;
      clr_pend <= 1'b0; ld_en <= 1'b0; ld_sel <= 1'b0; ld_idx <= '0;
      sample <= '0; sample_ch <= '0; sample_valid <= 1'b0;
    end else begin
      clr_pend <= 1'b0;
      if (clr_pend)
        for (int k = 0; k < 4; k++) begin
          hist[ch][k] <= '0;
          wgt[ch][k]  <= '0;
        end
      case (state)
        IDLE: if (accept) begin
          ch       <= in_ch;
          sf       <= spi_in[7:4];
          qr       <= spi_in[3:1];
          ld_sel   <= spi_in[1];
          ld_idx   <= spi_in[3:2];
          ld_en    <= ch_ok;
          tap      <= '0;
          clr_pend <= is_clr && ch_ok;
        end
        LOAD_HI: if (accept && ld_en) begin
          if (ld_sel) wgt[ch][ld_idx][15:8]  <= spi_in;
          else        hist[ch][ld_idx][15:8] <= spi_in;
        end
        LOAD_LO: if (accept && ld_en) begin
          if (ld_sel) wgt[ch][ld_idx][7:0]  <= spi_in;
          else        hist[ch][ld_idx][7:0] <= spi_in;
        end
        MAC: begin
          if (tap == 2'd0) dq <= qoa_rom(sf, qr);
          acc <= acc_nxt;
          tap <= tap + 2'd1;
          if (tap == 2'd3) begin
            sample       <= s_clamp;
            sample_ch    <= ch;
            sample_valid <= 1'b1;
          end
        end
        OUT: if (handshake) begin
          // sign test uses pre-shift history, matching the taps that produced the sample
          for (int k = 0; k < 4; k++)
            wgt[ch][k] <= wgt[ch][k] + (hist[ch][k][15] ? -delta : delta);
          for (int k = 0; k < 3; k++)
            hist[ch][k] <= hist[ch][k+1];
          hist[ch][3]  <= sample;
          acc          <= '0;
          sample_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
